// File: rtl/traffic_light_monitor.sv
// Passive checker on the Red/Green/Yellow lamp lines. It tracks the current phase, flags
// non-one-hot lamps, illegal phase order and wrong phase lengths, and counts legal transitions.
module traffic_light_monitor #(
   parameter int RED_CYCLES    = 5,
   parameter int GREEN_CYCLES  = 4,
   parameter int YELLOW_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Red,
   input  logic        Green,
   input  logic        Yellow,
   input  logic        clear_err,
   output logic [1:0]  phase,
   output logic        locked,
   output logic        err_onehot,
   output logic        err_order,
   output logic        err_duration,
   output logic        error,
   output logic [15:0] trans_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RED    = 2'd1,
      GREEN  = 2'd2,
      YELLOW = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RED_DUR    = CNT_W'(RED_CYCLES);
   localparam logic [CNT_W-1:0] GREEN_DUR  = CNT_W'(GREEN_CYCLES);
   localparam logic [CNT_W-1:0] YELLOW_DUR = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] RUN_MAX    = {CNT_W{1'b1}};

   state_t           state_reg, state_next;
   state_t           pat_state, succ_state;
   logic             pat_legal;
   logic [CNT_W-1:0] run_reg, run_next, dur_cur, run_inc;
   logic             partial_reg, partial_next;
   logic             locked_reg, locked_next;
   logic             onehot_reg, onehot_next;
   logic             order_reg, order_next;
   logic             duration_reg, duration_next;
   logic             error_reg, error_next;
   logic [15:0]      trans_reg, trans_next;

   always_comb begin
      pat_legal = 1'b0;
      pat_state = IDLE;
      case ({Red, Green, Yellow})
         3'b100: begin pat_legal = 1'b1; pat_state = RED;    end
         3'b010: begin pat_legal = 1'b1; pat_state = GREEN;  end
         3'b001: begin pat_legal = 1'b1; pat_state = YELLOW; end
         default: begin pat_legal = 1'b0; pat_state = IDLE;  end
      endcase
   end

   always_comb begin
      succ_state = IDLE;
      dur_cur    = '0;
      case (state_reg)
         RED:     begin succ_state = GREEN;  dur_cur = RED_DUR;    end
         GREEN:   begin succ_state = YELLOW; dur_cur = GREEN_DUR;  end
         YELLOW:  begin succ_state = RED;    dur_cur = YELLOW_DUR; end
         default: begin succ_state = IDLE;   dur_cur = '0;         end
      endcase
   end

   // Saturate so a stuck phase can never wrap back through DUR and hide an overrun.
   assign run_inc = (run_reg == RUN_MAX) ? run_reg : run_reg + CNT_W'(1);

   always_comb begin
      state_next    = state_reg;
      run_next      = run_reg;
      partial_next  = partial_reg;
      locked_next   = locked_reg;
      trans_next    = trans_reg;
      onehot_next   = 1'b0;
      order_next    = 1'b0;
      duration_next = 1'b0;

      if (!pat_legal) begin
         onehot_next  = 1'b1;
         state_next   = IDLE;
         locked_next  = 1'b0;
         run_next     = '0;
         partial_next = 1'b1;
      end else if (state_reg == IDLE) begin
         state_next   = pat_state;
         run_next     = CNT_W'(1);
         partial_next = 1'b1;
      end else if (pat_state == state_reg) begin
         run_next = run_inc;
         if (!partial_reg && run_reg == dur_cur) duration_next = 1'b1;
      end else if (pat_state == succ_state) begin
         if (!partial_reg && run_reg < dur_cur) duration_next = 1'b1;
         state_next   = succ_state;
         run_next     = CNT_W'(1);
         partial_next = 1'b0;
         locked_next  = 1'b1;
         trans_next   = trans_reg + 16'd1;
      end else begin
         order_next   = 1'b1;
         state_next   = pat_state;
         run_next     = CNT_W'(1);
         partial_next = 1'b1;
         locked_next  = 1'b0;
      end

      // A new pulse in the same cycle as clear_err keeps the flag set.
      error_next = onehot_next | order_next | duration_next | (error_reg & ~clear_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         run_reg      <= '0;
         partial_reg  <= 1'b1;
         locked_reg   <= 1'b0;
         onehot_reg   <= 1'b0;
         order_reg    <= 1'b0;
         duration_reg <= 1'b0;
         error_reg    <= 1'b0;
         trans_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         run_reg      <= run_next;
         partial_reg  <= partial_next;
         locked_reg   <= locked_next;
         onehot_reg   <= onehot_next;
         order_reg    <= order_next;
         duration_reg <= duration_next;
         error_reg    <= error_next;
         trans_reg    <= trans_next;
      end
   end

   assign phase        = state_reg;
   assign locked       = locked_reg;
   assign err_onehot   = onehot_reg;
   assign err_order    = order_reg;
   assign err_duration = duration_reg;
   assign error        = error_reg;
   assign trans_count  = trans_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp streams, all
// compared against a phase/run-length reference model kept here.
module tb_traffic_light_monitor;

   localparam int RC = 5;
   localparam int GC = 4;
   localparam int YC = 2;
   localparam logic [2:0] LR = 3'b100;
   localparam logic [2:0] LG = 3'b010;
   localparam logic [2:0] LY = 3'b001;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        red = 1'b0, green = 1'b0, yellow = 1'b0, clear_err = 1'b0;
   logic [1:0]  phase;
   logic        locked, err_onehot, err_order, err_duration, error;
   logic [15:0] trans_count;
   logic [22:0] obs;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_phase, m_run, m_trans;
   bit m_partial, m_locked, m_oh, m_ord, m_du, m_error;

   traffic_light_monitor #(
      .RED_CYCLES(RC), .GREEN_CYCLES(GC), .YELLOW_CYCLES(YC), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .Red(red), .Green(green), .Yellow(yellow),
      .clear_err(clear_err), .phase(phase), .locked(locked), .err_onehot(err_onehot),
      .err_order(err_order), .err_duration(err_duration), .error(error),
      .trans_count(trans_count)
   );

   always #5 clk = ~clk;

   assign obs = {phase, locked, err_onehot, err_order, err_duration, error, trans_count};

   function automatic int dur(input int ph);
      case (ph)
         1: return RC;
         2: return GC;
         3: return YC;
         default: return 0;
      endcase
   endfunction

   function automatic logic [22:0] model_vec();
      return {2'(m_phase), m_locked, m_oh, m_ord, m_du, m_error, 16'(m_trans)};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_run = 0; m_trans = 0; m_partial = 1'b1; m_locked = 1'b0;
      m_oh = 1'b0; m_ord = 1'b0; m_du = 1'b0; m_error = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] lamps, input logic clr);
      int ones, p;
      ones = int'(lamps[2]) + int'(lamps[1]) + int'(lamps[0]);
      m_oh = 1'b0; m_ord = 1'b0; m_du = 1'b0;
      if (ones != 1) begin
         m_oh = 1'b1; m_phase = 0; m_locked = 1'b0; m_run = 0; m_partial = 1'b1;
      end else begin
         p = lamps[2] ? 1 : (lamps[1] ? 2 : 3);
         if (m_phase == 0) begin
            m_phase = p; m_run = 1; m_partial = 1'b1;
         end else if (p == m_phase) begin
            if (!m_partial && m_run == dur(m_phase)) m_du = 1'b1;
            if (m_run < 255) m_run++;
         end else if (p == m_phase % 3 + 1) begin
            if (!m_partial && m_run < dur(m_phase)) m_du = 1'b1;
            m_phase = p; m_run = 1; m_partial = 1'b0; m_locked = 1'b1;
            m_trans = (m_trans + 1) % 65536;
         end else begin
            m_ord = 1'b1; m_phase = p; m_run = 1; m_partial = 1'b1; m_locked = 1'b0;
         end
      end
      m_error = m_oh | m_ord | m_du | (m_error & !clr);
   endtask

   // Drive one sample, let the edge happen, update the model, settle.
   task automatic cycle(input logic [2:0] lamps, input logic clr);
      {red, green, yellow} = lamps;
      clear_err = clr;
      @(posedge clk);
      model_step(lamps, clr);
      #1;
      $display("t=%0t lamps=%b clr=%b phase=%0d locked=%b pulses=%b%b%b error=%b trans=%0d",
               $time, lamps, clr, phase, locked, err_onehot, err_order, err_duration,
               error, trans_count);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      {red, green, yellow} = LR;
      clear_err = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 23'd0) begin
         errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 23'd0);
      end
      reset = 1'b1;
      cycle(LR, 1'b0);
      checks++;
      if (phase !== 2'd1 || locked !== 1'b0 || error !== 1'b0) begin
         errors++; $display("FAIL first_sample got phase=%0d locked=%b error=%b want 1 0 0",
                            phase, locked, error);
      end
      checks++;
      if (obs !== model_vec()) begin
         errors++; $display("FAIL first_sample_model got=%h want=%h", obs, model_vec());
      end
   endtask

   task automatic test_legal_cycling();
      logic [2:0] seq[$];
      apply_reset();
      seq.push_back(LR);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < GC; i++) seq.push_back(LG);
         for (int i = 0; i < YC; i++) seq.push_back(LY);
         for (int i = 0; i < RC; i++) seq.push_back(LR);
      end
      foreach (seq[i]) begin
         cycle(seq[i], 1'b0);
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL legal_cycle[%0d] got=%h want=%h", i, obs, model_vec());
         end
         if (i == 1) begin
            checks++;
            if (locked !== 1'b1) begin
               errors++; $display("FAIL lock_on_first_green got=%b want=1", locked);
            end
         end
      end
      checks++;
      if (trans_count !== 16'd9 || error !== 1'b0 || locked !== 1'b1) begin
         errors++; $display("FAIL legal_cycle_end got trans=%0d error=%b locked=%b want 9 0 1",
                            trans_count, error, locked);
      end
   endtask

   task automatic test_duration();
      apply_reset();
      cycle(LR, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(LG, 1'b0);
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL short_green[%0d] got=%h want=%h", i, obs, model_vec());
         end
      end
      cycle(LY, 1'b0);
      checks++;
      if (err_duration !== 1'b1 || obs !== model_vec()) begin
         errors++; $display("FAIL underrun got dur=%b obs=%h want dur=1 obs=%h",
                            err_duration, obs, model_vec());
      end
      cycle(LY, 1'b0);
      for (int i = 0; i < RC; i++) cycle(LR, 1'b0);
      checks++;
      if (obs !== model_vec()) begin
         errors++; $display("FAIL after_underrun got=%h want=%h", obs, model_vec());
      end
      for (int i = 0; i < 6; i++) begin
         cycle(LG, 1'b0);
         checks++;
         if (err_duration !== (i == GC) || obs !== model_vec()) begin
            errors++; $display("FAIL long_green[%0d] got dur=%b obs=%h want dur=%b obs=%h",
                               i, err_duration, obs, (i == GC), model_vec());
         end
      end
      cycle(LY, 1'b0);
      checks++;
      if (err_duration !== 1'b0 || obs !== model_vec()) begin
         errors++; $display("FAIL overrun_exit got dur=%b obs=%h want dur=0 obs=%h",
                            err_duration, obs, model_vec());
      end
   endtask

   task automatic test_order_and_sticky();
      apply_reset();
      cycle(LR, 1'b0);
      for (int i = 0; i < GC; i++) cycle(LG, 1'b0);
      for (int i = 0; i < YC; i++) cycle(LY, 1'b0);
      for (int i = 0; i < 2; i++) cycle(LR, 1'b0);
      cycle(LY, 1'b1);
      checks++;
      if (err_order !== 1'b1 || phase !== 2'd3 || locked !== 1'b0 || error !== 1'b1) begin
         errors++; $display("FAIL order_err got ord=%b phase=%0d locked=%b error=%b want 1 3 0 1",
                            err_order, phase, locked, error);
      end
      cycle(LR, 1'b1);
      checks++;
      if (err_duration !== 1'b0 || locked !== 1'b1 || error !== 1'b0 ||
          obs !== model_vec()) begin
         errors++; $display("FAIL order_recover got dur=%b locked=%b error=%b want 0 1 0",
                            err_duration, locked, error);
      end
   endtask

   task automatic test_onehot();
      apply_reset();
      cycle(LR, 1'b0);
      cycle(LG, 1'b0);
      cycle(3'b110, 1'b0);
      checks++;
      if (err_onehot !== 1'b1 || err_order !== 1'b0 || phase !== 2'd0) begin
         errors++; $display("FAIL onehot_110 got oh=%b ord=%b phase=%0d want 1 0 0",
                            err_onehot, err_order, phase);
      end
      cycle(3'b000, 1'b0);
      checks++;
      if (err_onehot !== 1'b1 || phase !== 2'd0 || obs !== model_vec()) begin
         errors++; $display("FAIL onehot_000 got oh=%b phase=%0d want 1 0", err_onehot, phase);
      end
      cycle(LG, 1'b0);
      checks++;
      if (phase !== 2'd2 || locked !== 1'b0 || err_onehot !== 1'b0 || err_order !== 1'b0) begin
         errors++; $display("FAIL onehot_resync got phase=%0d locked=%b want 2 0", phase, locked);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      cycle(LR, 1'b0);
      cycle(LG, 1'b0);
      cycle(3'b011, 1'b0);
      cycle(LG, 1'b0);
      reset = 1'b0;
      model_reset();
      #2;
      checks++;
      if (obs !== 23'd0 || obs !== model_vec()) begin
         errors++; $display("FAIL async_reset got=%h want=%h", obs, 23'd0);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_random();
      int gp, len;
      logic [2:0] lamps;
      logic clr;
      apply_reset();
      gp = 1;
      len = 2;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            lamps = 3'($urandom_range(0, 7));
         end else begin
            lamps = LR >> (gp - 1);
            len--;
            if (len <= 0) begin
               gp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : gp % 3 + 1;
               len = dur(gp) + int'($urandom_range(0, 3)) - 1;
               if (len < 1) len = 1;
            end
         end
         clr = ($urandom_range(0, 7) == 0);
         cycle(lamps, clr);
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL random[%0d] got=%h want=%h", n, obs, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_legal_cycling();
      test_duration();
      test_order_and_sticky();
      test_onehot();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

endmodule
